// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM state, trace entry layout, default region tags and fault word for the MMIO router.
package mmio_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int TR_ENTRY_W    = 64;
    localparam int TR_DATA_LSB   = 0;
    localparam int TR_DATA_W     = 32;
    localparam int TR_ADDR_LSB   = 32;
    localparam int TR_ADDR_W     = 10;
    localparam int TR_FAULT_BIT  = 42;
    localparam int TR_WE_BIT     = 43;
    localparam int TR_REGION_LSB = 44;
    localparam int TR_REGION_W   = 4;
    localparam int TR_STAMP_LSB  = 48;
    localparam int TR_STAMP_W    = 16;

    localparam logic [3:0] TAG_VMEM   = 4'hc;
    localparam logic [3:0] TAG_TIMER  = 4'hd;
    localparam logic [3:0] TAG_KBD    = 4'he;
    localparam logic [3:0] TAG_LOADER = 4'hf;

    localparam logic [31:0] FAULT_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [TR_ENTRY_W-1:0] trace_entry(
        input logic [TR_STAMP_W-1:0]  stamp,
        input logic [TR_REGION_W-1:0] region,
        input logic                   we,
        input logic                   fault,
        input logic [TR_ADDR_W-1:0]   addr,
        input logic [TR_DATA_W-1:0]   data
    );
        logic [TR_ENTRY_W-1:0] e;
        e = '0;
        e[TR_STAMP_LSB +: TR_STAMP_W]   = stamp;
        e[TR_REGION_LSB +: TR_REGION_W] = region;
        e[TR_WE_BIT]                    = we;
        e[TR_FAULT_BIT]                 = fault;
        e[TR_ADDR_LSB +: TR_ADDR_W]     = addr;
        e[TR_DATA_LSB +: TR_DATA_W]     = data;
        return e;
    endfunction
endpackage

// File: rtl/mmio_region_router_if.sv
// mmio_region_router_if: CPU data port, cache pass-through and device req/ack bundle.
interface mmio_region_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int DEV_ADDR_W  = 13
);
    logic [29:0]               cpu_addr;
    logic                      cpu_rd;
    logic                      cpu_wr;
    logic [3:0]                cpu_be;
    logic [31:0]               cpu_wdata;
    logic [31:0]               cpu_rdata;
    logic                      cpu_stall;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [31:0]               mem_rdata;
    logic [NUM_REGIONS-1:0]    dev_sel;
    logic                      dev_we;
    logic [DEV_ADDR_W-1:0]     dev_addr;
    logic [3:0]                dev_be;
    logic [31:0]               dev_wdata;
    logic [NUM_REGIONS-1:0]    dev_ack;
    logic [NUM_REGIONS*32-1:0] dev_rdata;

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_be, cpu_wdata, mem_rdata, dev_ack, dev_rdata,
        output cpu_rdata, cpu_stall, mem_rd, mem_wr, dev_sel, dev_we, dev_addr, dev_be, dev_wdata
    );

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_be, cpu_wdata, mem_rdata, dev_ack, dev_rdata,
        input  cpu_rdata, cpu_stall, mem_rd, mem_wr, dev_sel, dev_we, dev_addr, dev_be, dev_wdata
    );
endinterface

// File: rtl/mmio_trace_buf.sv
// mmio_trace_buf: circular access trace; once full each push overwrites the oldest entry.
module mmio_trace_buf #(
    parameter int DEPTH = 64,
    parameter int W     = 64
) (
    input  logic                     ui_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             entry,
    input  logic [$clog2(DEPTH)-1:0] idx,
    output logic [W-1:0]             data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] head;
    logic          full;

    assign full = count[IW];

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            head  <= '0;
            count <= '0;
        end else if (push) begin
            if (full) head <= head + 1'b1;
            else count <= count + 1'b1;
        end
    end

    // When full, head + count wraps back onto head, so the oldest slot is reused.
    always_ff @(posedge ui_clk)
        if (rst && push) mem[head + count[IW-1:0]] <= entry;

    assign data = {1'b0, idx} < count ? mem[head + idx] : '0;
endmodule

// File: rtl/mmio_region_router.sv
// mmio_region_router: decodes cpu_addr[29:26] against region tags and runs one req/ack handshake per device access.
// Define MMIO_TRACE_EN to build the access trace buffer and its stamp counter.
module mmio_region_router
    import mmio_pkg::*;
#(
    parameter int                       NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*4-1:0] REGION_TAGS = {TAG_LOADER, TAG_KBD, TAG_TIMER, TAG_VMEM},
    parameter int                       DEV_ADDR_W  = 13,
    parameter int                       TIMEOUT_CYC = 255,
    parameter logic [31:0]              FAULT_DATA  = FAULT_DATA_DEFAULT,
    parameter int                       TRACE_DEPTH = 64
) (
    input  logic                           ui_clk,
    input  logic                           rst,
    mmio_region_router_if.slave            bus,
    output logic [NUM_REGIONS-1:0]         fault_status,
    input  logic                           fault_clr,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [63:0]                    trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t                 state, state_n;
    logic [NUM_REGIONS-1:0] hit_oh, sel_q;
    logic                   hit, ack, timeout;
    logic [CW-1:0]          cnt;
    logic [31:0]            ack_data, rdata_q;
    logic                   unused_addr;

    assign unused_addr = ^bus.cpu_addr;

    // Scan downwards so the lowest matching region index wins.
    always_comb begin
        hit_oh = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if ((bus.cpu_rd || bus.cpu_wr) && bus.cpu_addr[29:26] == REGION_TAGS[4*i +: 4])
                hit_oh = NUM_REGIONS'(1) << i;
    end

    always_comb begin
        ack_data = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (sel_q[i]) ack_data = bus.dev_rdata[32*i +: 32];
    end

    assign hit     = |hit_oh;
    assign ack     = |(bus.dev_ack & sel_q);
    assign timeout = state == REQ && !ack && cnt == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge ui_clk)
        state <= !rst ? IDLE : state_n;

    always_comb
        state_n = state == IDLE ? (hit ? REQ : IDLE) :
                  state == REQ  ? (ack || timeout ? DONE : REQ) : IDLE;

    always_comb begin
        bus.dev_sel   = state == REQ ? sel_q : '0;
        bus.cpu_stall = hit && state != DONE;
        bus.mem_rd    = bus.cpu_rd && !hit;
        bus.mem_wr    = bus.cpu_wr && !hit;
        bus.cpu_rdata = hit ? rdata_q : bus.mem_rdata;
    end

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            sel_q         <= '0;
            bus.dev_we    <= 1'b0;
            bus.dev_addr  <= '0;
            bus.dev_be    <= '0;
            bus.dev_wdata <= '0;
            cnt           <= '0;
            rdata_q       <= '0;
            fault_status  <= '0;
        end else begin
            fault_status <= (fault_clr ? '0 : fault_status) | (timeout ? sel_q : '0);
            if (state == IDLE && hit) begin
                sel_q         <= hit_oh;
                bus.dev_we    <= bus.cpu_wr;
                bus.dev_addr  <= bus.cpu_addr[DEV_ADDR_W-1:0];
                bus.dev_be    <= bus.cpu_be;
                bus.dev_wdata <= bus.cpu_wdata;
                cnt           <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
                if (ack) rdata_q <= ack_data;
                else if (timeout) rdata_q <= FAULT_DATA;
            end
        end
    end

`ifdef MMIO_TRACE_EN
    logic [15:0] stamp;
    logic        fault_q;
    logic [3:0]  region;
    logic [9:0]  addr_lo;

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            stamp   <= '0;
            fault_q <= 1'b0;
        end else begin
            stamp <= stamp + 1'b1;
            if (state == IDLE && hit) fault_q <= 1'b0;
            else if (timeout) fault_q <= 1'b1;
        end
    end

    always_comb begin
        region = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (sel_q[i]) region = 4'(i);
    end

    assign addr_lo = 10'(bus.dev_addr);

    mmio_trace_buf #(.DEPTH(TRACE_DEPTH), .W(TR_ENTRY_W)) u_trace (
        .ui_clk(ui_clk),
        .rst(rst),
        .push(state == DONE),
        .entry(trace_entry(stamp, region, bus.dev_we, fault_q, addr_lo,
                           bus.dev_we ? bus.dev_wdata : rdata_q)),
        .idx(trace_idx),
        .data(trace_data),
        .count(trace_count)
    );
`else
    logic unused_trace;

    assign unused_trace = ^trace_idx;
    assign trace_data   = '0;
    assign trace_count  = '0;
`endif
endmodule

// File: tb/tb_mmio_region_router.sv
// tb_mmio_region_router: directed decode table plus handshake, timeout, reset and trace sequences.
module tb_mmio_region_router;
    localparam int NR = 4;
    localparam int AW = 13;
    localparam int TO = 8;
    localparam int TD = 4;
`ifdef MMIO_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        ui_clk = 1'b0;
    logic        rst = 1'b0;
    logic        fault_clr = 1'b0;
    logic [3:0]  fault_status;
    logic [1:0]  trace_idx = '0;
    logic [63:0] trace_data;
    logic [2:0]  trace_count;
    int          errors = 0;
    int          checks = 0;

    mmio_region_router_if #(.NUM_REGIONS(NR), .DEV_ADDR_W(AW)) bus();

    mmio_region_router #(.NUM_REGIONS(NR), .DEV_ADDR_W(AW), .TIMEOUT_CYC(TO), .TRACE_DEPTH(TD)) dut (
        .ui_clk(ui_clk),
        .rst(rst),
        .bus(bus),
        .fault_status(fault_status),
        .fault_clr(fault_clr),
        .trace_idx(trace_idx),
        .trace_data(trace_data),
        .trace_count(trace_count)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct {
        logic [29:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] mdata;
        logic        e_mem_rd;
        logic        e_mem_wr;
        logic        e_stall;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One CPU access; device acks in its ack_k-th dev_sel cycle (0 = never), noise acks other regions.
    task automatic access(input logic [29:0] addr, input logic rd, input logic wr, input logic [3:0] be,
                          input logic [31:0] wdata, input int ack_k, input logic [3:0] ack_oh,
                          input logic [3:0] noise, input logic [31:0] ack_data,
                          output int stall_n, output int sel_n, output logic [31:0] rdata,
                          output logic [3:0] fs, output bit held_ok);
        bit done = 1'b0;
        stall_n = 0;
        sel_n   = 0;
        held_ok = 1'b1;
        rdata   = '0;
        fs      = '0;
        @(posedge ui_clk); #1;
        bus.cpu_addr  = addr;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_be    = be;
        bus.cpu_wdata = wdata;
        for (int i = 0; i < 4; i++)
            bus.dev_rdata[32*i +: 32] = ack_oh[i] ? ack_data : (32'hBAD0_0000 | 32'(i));
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            bus.dev_ack = '0;
            if (bus.mem_rd || bus.mem_wr) held_ok = 1'b0;
            if (bus.dev_sel != 0) begin
                sel_n++;
                if (bus.dev_we !== wr || bus.dev_be !== be || bus.dev_wdata !== wdata ||
                    bus.dev_addr !== addr[AW-1:0]) held_ok = 1'b0;
                bus.dev_ack = noise | (sel_n == ack_k ? ack_oh : 4'b0);
            end
            if (bus.cpu_stall) stall_n++;
            else begin
                done  = 1'b1;
                rdata = bus.cpu_rdata;
                fs    = fault_status;
            end
            @(posedge ui_clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_bound: stall still high after 300 cycles, required release");
        end
        bus.cpu_rd  = 1'b0;
        bus.cpu_wr  = 1'b0;
        bus.dev_ack = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          sn, seln;
        logic [31:0] rd;
        logic [3:0]  fs;
        bit          ok;
        logic [63:0] e2, e5;
        bus.cpu_addr  = '0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_be    = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.dev_ack   = '0;
        bus.dev_rdata = '0;
        vecs[0] = '{30'h0000_0010, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001};
        vecs[1] = '{30'h0000_0010, 1'b0, 1'b1, 32'hCAFE_0002, 1'b0, 1'b1, 1'b0, 32'hCAFE_0002};
        vecs[2] = '{30'h3C00_0004, 1'b0, 1'b0, 32'hCAFE_0003, 1'b0, 1'b0, 1'b0, 32'hCAFE_0003};
        vecs[3] = '{30'h3C00_0004, 1'b1, 1'b0, 32'hCAFE_0004, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{30'h3000_0020, 1'b0, 1'b1, 32'hCAFE_0005, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{30'h2C00_0001, 1'b1, 1'b0, 32'hCAFE_0006, 1'b1, 1'b0, 1'b0, 32'hCAFE_0006};
        vecs[6] = '{30'h3400_0008, 1'b1, 1'b1, 32'hCAFE_0007, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[7] = '{30'h0000_0100, 1'b1, 1'b1, 32'hCAFE_0008, 1'b1, 1'b1, 1'b0, 32'hCAFE_0008};

        repeat (3) @(posedge ui_clk);
        #1 rst = 1'b1;
        #1;
        chk("reset_dev_sel", bus.dev_sel, 0);
        chk("reset_dev_we", bus.dev_we, 0);
        chk("reset_dev_addr", bus.dev_addr, 0);
        chk("reset_dev_be", bus.dev_be, 0);
        chk("reset_dev_wdata", bus.dev_wdata, 0);
        chk("reset_fault", fault_status, 0);
        chk("reset_stall", bus.cpu_stall, 0);
        chk("reset_trace_count", trace_count, 0);
        chk("reset_trace_data", trace_data, 0);

        // Decode table: inputs are withdrawn before the next rising edge, so the FSM stays in IDLE.
        for (int v = 0; v < 8; v++) begin
            @(negedge ui_clk);
            bus.cpu_addr  = vecs[v].addr;
            bus.cpu_rd    = vecs[v].rd;
            bus.cpu_wr    = vecs[v].wr;
            bus.mem_rdata = vecs[v].mdata;
            #1;
            chk($sformatf("vec%0d_mem_rd", v), bus.mem_rd, vecs[v].e_mem_rd);
            chk($sformatf("vec%0d_mem_wr", v), bus.mem_wr, vecs[v].e_mem_wr);
            chk($sformatf("vec%0d_stall", v), bus.cpu_stall, vecs[v].e_stall);
            chk($sformatf("vec%0d_rdata", v), bus.cpu_rdata, vecs[v].e_rdata);
            chk($sformatf("vec%0d_dev_sel", v), bus.dev_sel, 0);
            #1;
            bus.cpu_rd = 1'b0;
            bus.cpu_wr = 1'b0;
        end
        bus.mem_rdata = 32'h5555_AAAA;

        access(30'h3000_0010, 1'b1, 1'b0, 4'hF, 32'h0, 2, 4'b0001, 4'b0010, 32'h1234_5678, sn, seln, rd, fs, ok);
        chk("rd_stall_cycles", sn, 3);
        chk("rd_sel_cycles", seln, 2);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_held", ok, 1);
        chk("rd_fault", fs, 0);

        access(30'h3000_0123, 1'b0, 1'b1, 4'b1000, 32'hAB, 5, 4'b0001, 4'b0100, 32'h7777_0000, sn, seln, rd, fs, ok);
        chk("wr_stall_cycles", sn, 6);
        chk("wr_sel_cycles", seln, 5);
        chk("wr_held_no_mem", ok, 1);

        access(30'h3800_0042, 1'b1, 1'b0, 4'hF, 32'h0, 0, 4'b0100, 4'b0001, 32'h0, sn, seln, rd, fs, ok);
        chk("to_stall_cycles", sn, 9);
        chk("to_sel_cycles", seln, 8);
        chk("to_rdata", rd, 32'hDEAD_BEEF);
        chk("to_fault_done", fs, 4'b0100);
        chk("to_fault_sticky", fault_status, 4'b0100);
        fault_clr = 1'b1;
        @(posedge ui_clk); #1;
        fault_clr = 1'b0;
        #1 chk("fault_clr", fault_status, 0);

        // fault_clr held through a timeout: the set must win on the timeout edge.
        fault_clr = 1'b1;
        access(30'h3400_0001, 1'b1, 1'b0, 4'hF, 32'h0, 0, 4'b0010, 4'b0000, 32'h0, sn, seln, rd, fs, ok);
        fault_clr = 1'b0;
        chk("set_wins_fault", fs, 4'b0010);
        chk("set_wins_then_clr", fault_status, 0);

        access(30'h3800_0007, 1'b0, 1'b1, 4'b0011, 32'h0BAD_F00D, 1, 4'b0100, 4'b0000, 32'h0, sn, seln, rd, fs, ok);
        chk("min_lat_stall", sn, 2);
        chk("min_lat_sel", seln, 1);

        // Reset during the third REQ cycle, then a late ack.
        @(posedge ui_clk); #1;
        bus.cpu_addr = 30'h3400_0005;
        bus.cpu_rd   = 1'b1;
        repeat (3) begin @(posedge ui_clk); #1; end
        #1 chk("rst_mid_sel_before", bus.dev_sel, 4'b0010);
        rst = 1'b0;
        @(posedge ui_clk); #1;
        rst = 1'b1;
        bus.cpu_rd  = 1'b0;
        bus.dev_ack = 4'b0010;
        #1;
        chk("rst_mid_dev_sel", bus.dev_sel, 0);
        chk("rst_mid_stall", bus.cpu_stall, 0);
        chk("rst_mid_dev_addr", bus.dev_addr, 0);
        @(posedge ui_clk); #1;
        bus.dev_ack = '0;
        #1;
        chk("late_ack_dev_sel", bus.dev_sel, 0);
        chk("late_ack_fault", fault_status, 0);
        chk("late_ack_trace_count", trace_count, 0);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] tag;
            logic       we;
            tag = 4'hc + 4'(i % 4);
            we  = 1'(i % 2);
            access({tag, 26'(i * 16 + 3)}, !we, we, 4'hF, 32'h2000_0000 + 32'(i), 1, 4'b0001 << (i % 4),
                   4'b0000, 32'h1000_0000 + 32'(i), sn, seln, rd, fs, ok);
            if (i == 0) chk("trace_acc_stall", sn, 2);
            if (i == 1) begin
                chk("trace_count_partial", trace_count, TR ? 3'd2 : 3'd0);
                trace_idx = 2'd2;
                #1 chk("trace_idx_out_of_range", trace_data, 0);
            end
        end
        chk("trace_count_full", trace_count, TR ? 3'd4 : 3'd0);
        trace_idx = 2'd0;
        #1 e2 = trace_data;
        chk("trace_oldest", e2[47:0], TR ? {4'd2, 1'b0, 1'b0, 10'd35, 32'h1000_0002} : 48'h0);
        trace_idx = 2'd3;
        #1 e5 = trace_data;
        chk("trace_newest", e5[47:0], TR ? {4'd1, 1'b1, 1'b0, 10'd83, 32'h2000_0005} : 48'h0);
        chk("trace_stamp_delta", 16'(e5[63:48] - e2[63:48]), TR ? 16'd12 : 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
